// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Bundle of every handshake and bus signal of the load/store
//               stage.
//               - upstream   : in_valid/in_ready plus the instruction fields
//               - memory     : mem_req/mem_ack request/completion port
//               - downstream : out_valid/out_ready plus the writeback record
//               The stage uses the "slave" modport. The environment around
//               it (pipeline, memory, writeback) uses the "master" modport.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if;
    // Upstream (ALU side)
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_dest;
    // Data memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // Downstream (writeback side)
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic [4:0]  out_wb_reg;
    logic [31:0] out_wb_data;
    logic        out_err;

    modport slave (
        input  in_valid, in_op, in_alu_result, in_store_data, in_dest,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output out_valid, out_wb_en, out_wb_reg, out_wb_data, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_alu_result, in_store_data, in_dest,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  out_valid, out_wb_en, out_wb_reg, out_wb_data, out_err,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS load/store stage. It takes the ALU result, the store
//               data and the destination register. It performs the lw/sw
//               access over a req/ack memory port and then presents one
//               registered writeback record per retired instruction.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - mem_stage_if.slave, which carries three groups:
//                        upstream in_*, memory mem_*, downstream out_*
// Parameters  : MEM_TIMEOUT - number of cycles mem_req stays high without
//               an ack before the access is aborted (must be >= 1)
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_stage_if.slave   bus
);

    localparam logic [1:0] C_OP_PASS = 2'b00;
    localparam logic [1:0] C_OP_LW   = 2'b01;
    localparam logic [1:0] C_OP_SW   = 2'b10;

    // The wait counter holds 0 .. MEM_TIMEOUT-1 while mem_req is high.
    localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic              mem_req_q,     mem_req_d;
    logic              mem_we_q,      mem_we_d;
    logic [31:0]       mem_addr_q,    mem_addr_d;
    logic [31:0]       mem_wdata_q,   mem_wdata_d;
    logic [4:0]        dest_q,        dest_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic              out_valid_q,   out_valid_d;
    logic              out_wb_en_q,   out_wb_en_d;
    logic [4:0]        out_wb_reg_q,  out_wb_reg_d;
    logic [31:0]       out_wb_data_q, out_wb_data_d;
    logic              out_err_q,     out_err_d;

    logic w_in_ready;
    logic w_accept;

    // The only combinational output. A held record that drains this cycle
    // frees the stage, so a new instruction can enter on the same edge.
    assign w_in_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        dest_d        = dest_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_wb_en_d   = out_wb_en_q;
        out_wb_reg_d  = out_wb_reg_q;
        out_wb_data_d = out_wb_data_q;
        out_err_d     = out_err_q;

        unique case (state_q)
            ST_MEM: begin
                // Ack has priority over the timeout in the last wait cycle.
                if (bus.mem_ack) begin
                    mem_req_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    out_wb_reg_d = dest_q;
                    out_err_d    = 1'b0;
                    if (mem_we_q) begin
                        out_wb_en_d   = 1'b0;
                        out_wb_data_d = mem_addr_q;
                    end else begin
                        out_wb_en_d   = (dest_q != 5'd0);
                        out_wb_data_d = bus.mem_rdata;
                    end
                    state_d = ST_OUT;
                end else if (cnt_q == C_CNT_LAST) begin
                    mem_req_d     = 1'b0;
                    out_valid_d   = 1'b1;
                    out_wb_reg_d  = dest_q;
                    out_wb_en_d   = 1'b0;
                    out_wb_data_d = mem_addr_q;
                    out_err_d     = 1'b1;
                    state_d       = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE, ST_OUT: begin
                // Drain first. A same-cycle accept below overrides this.
                if ((state_q == ST_OUT) && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                if (w_accept) begin
                    if (bus.in_op == C_OP_PASS) begin
                        out_valid_d   = 1'b1;
                        out_wb_en_d   = (bus.in_dest != 5'd0);
                        out_wb_reg_d  = bus.in_dest;
                        out_wb_data_d = bus.in_alu_result;
                        out_err_d     = 1'b0;
                        state_d       = ST_OUT;
                    end else if ((bus.in_op == C_OP_LW) || (bus.in_op == C_OP_SW)) begin
                        if (bus.in_alu_result[1:0] != 2'b00) begin
                            // Misaligned access: it never reaches memory.
                            out_valid_d   = 1'b1;
                            out_wb_en_d   = 1'b0;
                            out_wb_reg_d  = bus.in_dest;
                            out_wb_data_d = bus.in_alu_result;
                            out_err_d     = 1'b1;
                            state_d       = ST_OUT;
                        end else begin
                            mem_req_d   = 1'b1;
                            mem_we_d    = (bus.in_op == C_OP_SW);
                            mem_addr_d  = bus.in_alu_result;
                            mem_wdata_d = bus.in_store_data;
                            dest_d      = bus.in_dest;
                            cnt_d       = '0;
                            out_valid_d = 1'b0;
                            state_d     = ST_MEM;
                        end
                    end else begin
                        // Bubble: nothing is recorded.
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            dest_q        <= 5'd0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_wb_en_q   <= 1'b0;
            out_wb_reg_q  <= 5'd0;
            out_wb_data_q <= 32'd0;
            out_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            dest_q        <= dest_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_wb_en_q   <= out_wb_en_d;
            out_wb_reg_q  <= out_wb_reg_d;
            out_wb_data_q <= out_wb_data_d;
            out_err_q     <= out_err_d;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_wb_en   = out_wb_en_q;
    assign bus.out_wb_reg  = out_wb_reg_q;
    assign bus.out_wb_data = out_wb_data_q;
    assign bus.out_err     = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed, table-driven bench for mem_stage (MEM_TIMEOUT = 4).
//               Each table row drives the inputs for one cycle and gives the
//               expected in_ready before the edge and the expected registered
//               outputs after it. Hand-written sequences cover the reset
//               corners.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        vld;
        logic [1:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        ordy;
        logic        ack;
        logic [31:0] rdata;
        logic        e_inr;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ov;
        logic        e_en;
        logic        ck_reg;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic vld, input logic [1:0] op, input logic [31:0] alu, input logic [31:0] sd,
        input logic [4:0] dest, input logic ordy, input logic ack, input logic [31:0] rdata,
        input logic e_inr, input logic e_req, input logic e_we, input logic [31:0] e_addr,
        input logic [31:0] e_wdata, input logic e_ov, input logic e_en, input logic ck_reg,
        input logic [4:0] e_reg, input logic [31:0] e_data, input logic e_err);
        vec_t v;
        v.vld = vld; v.op = op; v.alu = alu; v.sd = sd; v.dest = dest; v.ordy = ordy;
        v.ack = ack; v.rdata = rdata; v.e_inr = e_inr; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_ov = e_ov; v.e_en = e_en;
        v.ck_reg = ck_reg; v.e_reg = e_reg; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [1:0] op, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] dest, input logic ordy,
                         input logic ack, input logic [31:0] rdata);
        bus.in_valid      = vld;
        bus.in_op         = op;
        bus.in_alu_result = alu;
        bus.in_store_data = sd;
        bus.in_dest       = dest;
        bus.out_ready     = ordy;
        bus.mem_ack       = ack;
        bus.mem_rdata     = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle cycle between groups: no valid, out_ready high, no ack.
        // Pass stream
        vq.push_back(mk(1, 2'b00, 32'h10, 0, 3, 1, 0, 0,  1, 0, 0, 0, 0,  1, 1, 1, 3, 32'h10, 0));
        vq.push_back(mk(1, 2'b00, 32'h11, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0,  1, 0, 1, 0, 32'h11, 0));
        vq.push_back(mk(1, 2'b00, 32'h12, 0, 7, 1, 0, 0,  1, 0, 0, 0, 0,  1, 1, 1, 7, 32'h12, 0));
        vq.push_back(mk(1, 2'b00, 32'h13, 0, 9, 1, 0, 0,  1, 0, 0, 0, 0,  1, 1, 1, 9, 32'h13, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // Misaligned lw: no request, 1-cycle error record
        vq.push_back(mk(1, 2'b01, 32'h102, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 32'h102, 1));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // lw with ack on the third request cycle
        vq.push_back(mk(1, 2'b01, 32'h100, 0, 8, 1, 0, 0, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       0, 1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 1, 1, 8, 32'hDEADBEEF, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // sw then lw to the same word
        vq.push_back(mk(1, 2'b10, 32'h40, 32'h12345678, 2, 1, 0, 0, 1, 1, 1, 32'h40, 32'h12345678, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 1, 32'hCAFE0000, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h40, 0));
        vq.push_back(mk(1, 2'b01, 32'h40, 0, 4, 1, 0, 0,  1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 1, 1, 4, 32'h12345678, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // Bubbles: from IDLE, and while a record drains
        vq.push_back(mk(1, 2'b11, 32'h77, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 2'b00, 32'h55, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0,  1, 1, 1, 1, 32'h55, 0));
        vq.push_back(mk(1, 2'b11, 32'h66, 0, 2, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // Timeout (4 cycles), then a stray ack two cycles later
        vq.push_back(mk(1, 2'b01, 32'h200, 0, 6, 1, 0, 0, 1, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       0, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       0, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       0, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h200, 1));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        // Backpressure for 5 cycles with a new op waiting
        vq.push_back(mk(1, 2'b00, 32'hABC, 0, 11, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 11, 32'hABC, 0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(1, 2'b00, 32'h999, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 11, 32'hABC, 0));
        vq.push_back(mk(1, 2'b00, 32'h999, 0, 12, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 12, 32'h999, 0));
        vq.push_back(mk(0, 2'b11, 0, 0, 0, 1, 0, 0,       1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

        // Reset state
        drive(0, 2'b11, 0, 0, 0, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst mem_req",     32'(bus.mem_req),     0);
        chk("rst mem_we",      32'(bus.mem_we),      0);
        chk("rst mem_addr",    bus.mem_addr,         0);
        chk("rst mem_wdata",   bus.mem_wdata,        0);
        chk("rst out_valid",   32'(bus.out_valid),   0);
        chk("rst out_wb_en",   32'(bus.out_wb_en),   0);
        chk("rst out_wb_reg",  32'(bus.out_wb_reg),  0);
        chk("rst out_wb_data", bus.out_wb_data,      0);
        chk("rst out_err",     32'(bus.out_err),     0);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        // Table-driven vectors
        foreach (vq[i]) begin
            drive(vq[i].vld, vq[i].op, vq[i].alu, vq[i].sd, vq[i].dest,
                  vq[i].ordy, vq[i].ack, vq[i].rdata);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vq[i].e_inr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req), 32'(vq[i].e_req));
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vq[i].e_ov));
            if (vq[i].e_req) begin
                chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vq[i].e_we));
                chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vq[i].e_addr);
                if (vq[i].e_we)
                    chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vq[i].e_wdata);
            end
            if (vq[i].e_ov) begin
                chk($sformatf("v%0d out_wb_en", i), 32'(bus.out_wb_en), 32'(vq[i].e_en));
                chk($sformatf("v%0d out_wb_data", i), bus.out_wb_data, vq[i].e_data);
                chk($sformatf("v%0d out_err", i), 32'(bus.out_err), 32'(vq[i].e_err));
                if (vq[i].ck_reg)
                    chk($sformatf("v%0d out_wb_reg", i), 32'(bus.out_wb_reg), 32'(vq[i].e_reg));
            end
            @(negedge clk);
        end

        // Reset during a memory wait: mem_req falls without an ack
        drive(1, 2'b01, 32'h300, 0, 3, 1, 0, 0);
        @(negedge clk);
        drive(0, 2'b11, 0, 0, 0, 1, 0, 0);
        #1;
        chk("rstmem req before", 32'(bus.mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmem mem_req", 32'(bus.mem_req), 0);
        chk("rstmem out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 2'b11, 0, 0, 0, 1, 1, 32'h11112222);
        #1;
        chk("rstmem in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        chk("rstmem late ack req", 32'(bus.mem_req), 0);
        chk("rstmem late ack valid", 32'(bus.out_valid), 0);
        @(negedge clk);

        // Reset while a record is held under backpressure
        drive(1, 2'b00, 32'h5A, 0, 3, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rstout valid before", 32'(bus.out_valid), 1);
        @(negedge clk);
        drive(0, 2'b11, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstout out_valid", 32'(bus.out_valid), 0);
        chk("rstout out_wb_data", bus.out_wb_data, 0);
        chk("rstout out_wb_en", 32'(bus.out_wb_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstout in_ready", 32'(bus.in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Load/store stage sitting directly downstream of the ALU in the MIPS datapath. It consumes the ALU `result` (address or arithmetic value) plus store data and destination register, and performs the data-memory access for `lw`/`sw` over a req/ack memory port. It presents one registered writeback record per retired instruction to the writeback stage, using valid/ready handshakes upstream and downstream so variable memory latency stalls the pipeline cleanly.

## Interface
- `MEM_TIMEOUT`, default 255: maximum cycles to wait for `mem_ack` before aborting the access (≥1).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage accepts this cycle (transfer = `in_valid & in_ready` at a rising edge).
- `in_op`  in  2  operation: 00 pass ALU result, 01 lw, 10 sw, 11 none (bubble: bne/j/jal-without-link).
- `in_alu_result`  in  32  ALU output: address for lw/sw, value for pass.
- `in_store_data`  in  32  rt value for sw.
- `in_dest`  in  5  destination register.
- `mem_req`  out  1  access request, held until ack or timeout.
- `mem_we`  out  1  1 = write (sw), 0 = read (lw); stable while `mem_req`.
- `mem_addr`  out  32  word address (byte address, bits [1:0] = 0); stable while `mem_req`.
- `mem_wdata`  out  32  store data; stable while `mem_req`.
- `mem_rdata`  in  32  read data, valid in the `mem_ack` cycle.
- `mem_ack`  in  1  single-cycle completion pulse.
- `out_valid`  out  1  writeback record valid.
- `out_ready`  in  1  writeback stage accepts.
- `out_wb_en`  out  1  write register file.
- `out_wb_reg`  out  5  destination register.
- `out_wb_data`  out  32  value to write.
- `out_err`  out  1  misaligned address or memory timeout.

## Operation
- States: IDLE (no record held), MEM (access outstanding), OUT (record held on `out_*`).
- `in_ready` = IDLE, or OUT with `out_ready`. Never asserted in MEM.
- Accept of op 00: load record {wb_en = (dest≠0), reg = dest, data = alu_result, err = 0}, go OUT.
- Accept of op 11: nothing recorded; go IDLE (OUT→IDLE when the held record drains in the same cycle).
- Accept of op 01/10 with `alu_result[1:0]≠0`: no memory access; record {wb_en = 0, data = alu_result, err = 1}, go OUT.
- Accept of aligned op 01/10: latch addr/wdata/we/dest, assert `mem_req` from the next cycle, go MEM, clear the wait counter.
- MEM: counter increments each cycle without ack. On `mem_ack`: drop `mem_req` next cycle; record lw → {wb_en = (dest≠0), data = mem_rdata, err = 0}, sw → {wb_en = 0, data = addr, err = 0}; go OUT.
- Timeout: counter reaches `MEM_TIMEOUT` without ack → drop `mem_req`; record {wb_en = 0, data = addr, err = 1}; go OUT.
- OUT with `out_ready` and no new accept → IDLE. OUT without `out_ready` → hold all `out_*` stable.
- `mem_ack` outside MEM (late ack after timeout or reset) is ignored.
- Exactly one record per accepted op 00/01/10; records are in order.

## Timing
- Reset (async, immediate): state IDLE, `in_ready` = 1 after reset release, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `out_valid` = 0, `out_wb_en` = 0, `out_wb_reg` = 0, `out_wb_data` = 0, `out_err` = 0, counter = 0. Reset mid-access abandons it; `mem_req` falls without waiting for ack.
- Pass/misaligned: accepted at edge N → `out_valid` high after edge N (1-cycle latency); back-to-back throughput 1/cycle when `out_ready` = 1.
- lw/sw: accepted at edge N → `mem_req` high after N; ack sampled at edge N+k (k≥1) → `out_valid` after N+k, `mem_req` low after N+k. Latency = k+1 cycles.
- Ack is honoured in the first cycle `mem_req` is high.
- Timeout: with no ack, `mem_req` is high for exactly `MEM_TIMEOUT` cycles; `out_valid`/`out_err` rise at the same edge at which `mem_req` falls.
- All outputs are registered except `in_ready` (combinational from state and `out_ready`).

## Test plan
- Pass stream: 4 op-00 ops, dest 3,0,7,9, values 0x10..0x13, `out_ready` = 1 → 4 records on consecutive cycles, wb_en = 1,0,1,1, `in_ready` constantly 1.
- lw, ack on 3rd req cycle: addr 0x100, rdata 0xDEADBEEF, dest 8 → `mem_req` high 3 cycles, we = 0, record {1, 8, 0xDEADBEEF, err 0}, `in_ready` low for 3 cycles.
- sw then lw to 0x40, wdata 0x12345678, ack after 1 cycle each → first req we = 1 with wdata, wb_en = 0; second read returns 0x12345678 with wb_en = 1; order preserved.
- Misaligned lw at 0x102 → no `mem_req`, record err = 1, wb_en = 0, 1-cycle latency.
- `MEM_TIMEOUT` = 4, no ack → req high exactly 4 cycles, record err = 1, data = addr; a stray ack 2 cycles later changes nothing.
- Backpressure plus reset: `out_ready` = 0 for 5 cycles holds the record stable and `in_ready` low; assert `rst_n` = 0 during a MEM wait → `mem_req` and `out_valid` drop immediately, IDLE after release.
